// File: rtl/grp_15_spi_master.sv
// Val/rdy packet to SPI mode-0 master; the response is held (2N+1)*CLK_DIV cycles after accept until recv_rdy,
// and send_rdy stays low while busy or a response is pending. Define SPI_MASTER_PARITY_EN to add recv_parity.
module grp_15_spi_master #(
   parameter int NBITS   = 34,
   parameter int CLK_DIV = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NBITS-1:0]           send_msg,
   input  logic                       send_val,
   output logic                       send_rdy,
   input  logic [$clog2(NBITS+1)-1:0] packet_size,
   output logic [NBITS-1:0]           recv_msg,
   output logic                       recv_val,
   input  logic                       recv_rdy,
   output logic                       spi_cs,
   output logic                       spi_sclk,
   output logic                       spi_mosi,
   input  logic                       spi_miso
`ifdef SPI_MASTER_PARITY_EN
   ,
   output logic                       recv_parity
`endif
);

   localparam int         PW       = $clog2(NBITS + 1);
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   typedef enum logic [2:0] {IDLE, CS_SETUP, SCLK_HIGH, SCLK_LOW, CS_HOLD, DONE} state_t;

   state_t           state, state_nxt;
   logic [7:0]       div_cnt, div_nxt;
   logic [PW-1:0]    bit_cnt, bit_nxt;
   logic [PW-1:0]    eff_n;
   logic [NBITS-1:0] tx, tx_nxt, tx_load, rx_nxt;
   logic             mosi_nxt;
   logic             div_last;

   always_comb begin
      if (packet_size == '0 || int'(packet_size) > NBITS) eff_n = PW'(NBITS);
      else                                                 eff_n = packet_size;
   end

   // The TX register keeps the next bit to send at its MSB regardless of packet size.
   assign tx_load  = send_msg << (NBITS - int'(eff_n));
   assign div_last = (div_cnt == DIV_LAST);

   always_comb begin
      state_nxt = state;
      div_nxt   = 8'd0;
      bit_nxt   = bit_cnt;
      tx_nxt    = tx;
      rx_nxt    = recv_msg;
      mosi_nxt  = spi_mosi;
      case (state)
         IDLE: begin
            if (send_val && send_rdy) begin
               state_nxt = CS_SETUP;
               tx_nxt    = tx_load;
               bit_nxt   = eff_n;
               rx_nxt    = '0;
               mosi_nxt  = tx_load[NBITS-1];
            end
         end
         CS_SETUP: begin
            if (div_last) state_nxt = SCLK_HIGH;
            else          div_nxt   = div_cnt + 8'd1;
         end
         SCLK_HIGH: begin
            if (div_last) begin
               rx_nxt  = {recv_msg[NBITS-2:0], spi_miso};
               bit_nxt = bit_cnt - PW'(1);
               if (bit_cnt == PW'(1)) begin
                  state_nxt = CS_HOLD;
               end else begin
                  state_nxt = SCLK_LOW;
                  tx_nxt    = {tx[NBITS-2:0], tx[NBITS-1]};
                  mosi_nxt  = tx[NBITS-2];
               end
            end else begin
               div_nxt = div_cnt + 8'd1;
            end
         end
         SCLK_LOW: begin
            if (div_last) state_nxt = SCLK_HIGH;
            else          div_nxt   = div_cnt + 8'd1;
         end
         CS_HOLD: begin
            if (div_last) begin
               state_nxt = DONE;
               mosi_nxt  = 1'b0;
            end else begin
               div_nxt = div_cnt + 8'd1;
            end
         end
         DONE: begin
            if (recv_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so no input reaches a pin combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         div_cnt  <= 8'd0;
         bit_cnt  <= '0;
         tx       <= '0;
         recv_msg <= '0;
         spi_cs   <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
         send_rdy <= 1'b1;
         recv_val <= 1'b0;
      end else begin
         state    <= state_nxt;
         div_cnt  <= div_nxt;
         bit_cnt  <= bit_nxt;
         tx       <= tx_nxt;
         recv_msg <= rx_nxt;
         spi_cs   <= (state_nxt == IDLE) || (state_nxt == DONE);
         spi_sclk <= (state_nxt == SCLK_HIGH);
         spi_mosi <= mosi_nxt;
         send_rdy <= (state_nxt == IDLE);
         recv_val <= (state_nxt == DONE);
      end
   end

`ifdef SPI_MASTER_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) recv_parity <= 1'b0;
      else       recv_parity <= ^rx_nxt;
   end
`endif

endmodule

// File: doc/grp_15_spi_master.md
# grp_15_spi_master

SPI master that drives the group 15 SPI minion pins (spi_min_cs, spi_min_sclk, spi_min_mosi, spi_min_miso) from a val/rdy packet interface. It sits directly upstream of the tapeout block, in the FPGA test harness or an on-chip self-test path. Each accepted packet becomes one chip-select framed, full-duplex SPI mode-0 transaction. The bits shifted in on MISO are returned as a val/rdy response packet.

## Interface
Parameters:
- NBITS, 34, maximum packet width (32 data + 2 flow-control bits).
- CLK_DIV, 2, SCLK half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  single clock; all flops on rising edge.
- reset  input  1  asynchronous, active-high reset.
- send_msg  input  NBITS  packet to transmit, LSB-aligned.
- send_val  input  1  send_msg valid.
- send_rdy  output  1  master idle; ready to accept a packet.
- packet_size  input  $clog2(NBITS+1)  bits to transfer; sampled with send handshake; 0 or >NBITS means NBITS.
- recv_msg  output  NBITS  bits captured from MISO, LSB-aligned, upper bits zero.
- recv_val  output  1  recv_msg valid.
- recv_rdy  input  1  consumer accepts recv_msg.
- spi_cs  output  1  chip select, active-low.
- spi_sclk  output  1  serial clock, idle low.
- spi_mosi  output  1  serial data to minion.
- spi_miso  input  1  serial data from minion.
- recv_parity  output  1  XOR of recv_msg; present only with the configuration macro.

## Operation
- All SPI outputs, send_rdy and recv_val come straight from flops; no combinational input-to-output paths.
- FSM states: IDLE, CS_SETUP, SCLK_HIGH, SCLK_LOW, CS_HOLD, DONE.
  - Every timed state lasts exactly CLK_DIV cycles, counted by a divider counter.
- IDLE:
  - Outputs: cs=1, sclk=0, send_rdy=1.
  - On send_val&&send_rdy: latch send_msg into the TX shift register, latch N (effective packet_size) into the bit counter, clear the RX register, go to CS_SETUP.
- CS_SETUP: cs=0, sclk=0, mosi=send_msg[N-1]. Then go to SCLK_HIGH.
- SCLK_HIGH:
  - sclk=1.
  - In the last cycle of the phase, register spi_miso into RX bit 0, shift RX left, and decrement the counter.
  - If the counter reaches 0, go to CS_HOLD. Otherwise go to SCLK_LOW.
- SCLK_LOW: sclk=0; mosi advances to the next lower bit on entry. Then go to SCLK_HIGH.
- Bit order is MSB-first on both MOSI and MISO. After N bits, recv_msg[N-1:0] holds the MISO bits in arrival order, first bit at N-1.
- CS_HOLD: cs=0, sclk=0. Then go to DONE.
- DONE:
  - Outputs: cs=1, recv_val=1, recv_msg stable, send_rdy=0.
  - On recv_rdy, go to IDLE.
- Exactly N rising edges of sclk occur per transaction. Back-to-back transactions always have cs high for at least 2 cycles (DONE + IDLE).
- A new send is never accepted while a response is pending.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, spi_cs=1, spi_sclk=0, spi_mosi=0, send_rdy=1, recv_val=0, recv_msg=0, counters=0.
- Let D=CLK_DIV and the send handshake occur at edge 0.
  - spi_cs falls after edge 0.
  - First sclk rise occurs D cycles later.
  - recv_val rises (2N+1)·D cycles after edge 0.
  - send_rdy rises 1 cycle after the recv handshake.
- MOSI setup to the sclk rise is D cycles. MISO is sampled D−1 cycles after the sclk rise, just before the fall.
- Reset mid-transaction: SPI lines return to idle immediately. Any partial packet is discarded and no response is produced.
- recv_rdy held high in advance: DONE lasts exactly 1 cycle.
- send_val while busy is ignored; the input stays pending until send_rdy.

## Configuration
- SPI_MASTER_PARITY_EN defined:
  - Adds the recv_parity output, equal to the XOR of all NBITS bits of recv_msg.
  - Registered alongside recv_msg, so it is valid whenever recv_val=1. Reset value is 0.
- SPI_MASTER_PARITY_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert reset mid-cycle -> immediately spi_cs=1, spi_sclk=0, spi_mosi=0, recv_val=0, send_rdy=1.
- Loopback (miso=mosi), NBITS=34, D=2, packet_size=0, send 0x2DEADBEEF -> recv_msg=0x2DEADBEEF, exactly 34 sclk rises, recv_val 138 cycles after the handshake.
- miso tied 1, packet_size=8, send 0xA5 -> mosi sequence 1,0,1,0,0,1,0,1 on the sclk rises, recv_msg=0x0FF, recv_val after 34 cycles.
- Backpressure: recv_rdy=0 for 10 cycles after recv_val -> recv_msg stable, spi_cs=1, send_rdy=0, a new send_val is ignored. The next send is accepted 1 cycle after the recv handshake.
- Reset after 5 sclk rises -> lines idle at once, no recv_val. A following 0x155 packet with packet_size=9 in loopback completes correctly.
- With SPI_MASTER_PARITY_EN: loopback 0x2DEADBEEF -> recv_parity=1. Loopback 0x3 with packet_size=2 -> recv_parity=0.
